// File: rtl/pix_write_arb_if.sv
// Pixel write bus between three burst requesters and the framebuffer arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface pix_write_arb_if;
    logic       R0_VALID, R1_VALID, R2_VALID;
    logic [7:0] R0_X, R1_X, R2_X;
    logic [7:0] R0_Y, R1_Y, R2_Y;
    logic [8:0] R0_RGB, R1_RGB, R2_RGB;
    logic       R0_LAST, R1_LAST, R2_LAST;
    logic       R0_READY, R1_READY, R2_READY;
    logic [7:0] X, Y;
    logic [2:0] R, G, B;
    logic       WE;
    logic [1:0] OWNER;
    logic       BUSY;

    modport slave (
        input  R0_VALID, R1_VALID, R2_VALID,
        input  R0_X, R1_X, R2_X, R0_Y, R1_Y, R2_Y,
        input  R0_RGB, R1_RGB, R2_RGB,
        input  R0_LAST, R1_LAST, R2_LAST,
        output R0_READY, R1_READY, R2_READY,
        output X, Y, R, G, B, WE, OWNER, BUSY
    );

    modport master (
        output R0_VALID, R1_VALID, R2_VALID,
        output R0_X, R1_X, R2_X, R0_Y, R1_Y, R2_Y,
        output R0_RGB, R1_RGB, R2_RGB,
        output R0_LAST, R1_LAST, R2_LAST,
        input  R0_READY, R1_READY, R2_READY,
        input  X, Y, R, G, B, WE, OWNER, BUSY
    );
endinterface

// File: rtl/pix_write_arb.sv
// Round-robin arbiter granting one of three pixel requesters whole bursts onto a
// single framebuffer write port, with MAXBURST and owner-idle forced release.
module pix_write_arb #(
    parameter int MAXBURST = 256,
    parameter int IDLE_TO  = 16
) (
    input logic             CLK,
    input logic             NRST,
    pix_write_arb_if.slave  bus
);
    typedef enum logic {ARB, GRANT} state_t;

    state_t     state_q;
    logic [1:0] owner_q, last_q;
    logic [8:0] beat_q, beat_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] x_q, y_q;
    logic [8:0] rgb_q;
    logic       we_q;

    // Slot 3 is a tied-off dummy so OWNER=3 never indexes out of range.
    logic [3:0]      vld, lst;
    logic [3:0][7:0] px, py;
    logic [3:0][8:0] prgb;

    assign vld  = {1'b0, bus.R2_VALID, bus.R1_VALID, bus.R0_VALID};
    assign lst  = {1'b0, bus.R2_LAST, bus.R1_LAST, bus.R0_LAST};
    assign px   = {8'd0, bus.R2_X, bus.R1_X, bus.R0_X};
    assign py   = {8'd0, bus.R2_Y, bus.R1_Y, bus.R0_Y};
    assign prgb = {9'd0, bus.R2_RGB, bus.R1_RGB, bus.R0_RGB};

    logic       has_sel;
    logic [1:0] sel;

    always_comb begin
        int start;
        has_sel = 1'b0;
        sel     = 2'd0;
        start   = (last_q == 2'd2) ? 0 : int'(last_q) + 1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = start + k;
            if (idx > 2) idx = idx - 3;
            if (!has_sel && vld[idx]) begin
                has_sel = 1'b1;
                sel     = 2'(idx);
            end
        end
    end

    logic [3:0] rdy;
    logic       acc;

    assign rdy    = (state_q == GRANT) ? (4'b0001 << owner_q) : 4'b0000;
    assign acc    = rdy[owner_q] & vld[owner_q];
    assign beat_d = beat_q + 9'd1;
    assign idle_d = idle_q + 8'd1;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= ARB;
            owner_q <= 2'd3;
            last_q  <= 2'd2;
            beat_q  <= '0;
            idle_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (has_sel) begin
                        state_q <= GRANT;
                        owner_q <= sel;
                        beat_q  <= '0;
                        idle_q  <= '0;
                    end
                end
                GRANT: begin
                    if (acc) begin
                        we_q   <= 1'b1;
                        x_q    <= px[owner_q];
                        y_q    <= py[owner_q];
                        rgb_q  <= prgb[owner_q];
                        beat_q <= beat_d;
                        idle_q <= '0;
                        if (lst[owner_q] || beat_d == 9'(MAXBURST)) begin
                            state_q <= ARB;
                            last_q  <= owner_q;
                            owner_q <= 2'd3;
                        end
                    end else begin
                        // Owner stalled: give the port away rather than starve others.
                        idle_q <= idle_d;
                        if (idle_d == 8'(IDLE_TO)) begin
                            state_q <= ARB;
                            last_q  <= owner_q;
                            owner_q <= 2'd3;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.R0_READY = rdy[0];
    assign bus.R1_READY = rdy[1];
    assign bus.R2_READY = rdy[2];
    assign bus.X        = x_q;
    assign bus.Y        = y_q;
    assign bus.R        = rgb_q[8:6];
    assign bus.G        = rgb_q[5:3];
    assign bus.B        = rgb_q[2:0];
    assign bus.WE       = we_q;
    assign bus.OWNER    = owner_q;
    assign bus.BUSY     = (state_q == GRANT);
endmodule
